// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
// Segment patterns are active-low, bit order {dp,g,f,e,d,c,b,a}.
package ssd_scan_ctrl_pkg;

    localparam logic [7:0] SS_0     = 8'hC0;
    localparam logic [7:0] SS_1     = 8'hF9;
    localparam logic [7:0] SS_2     = 8'hA4;
    localparam logic [7:0] SS_3     = 8'hB0;
    localparam logic [7:0] SS_4     = 8'h99;
    localparam logic [7:0] SS_5     = 8'h92;
    localparam logic [7:0] SS_6     = 8'h82;
    localparam logic [7:0] SS_7     = 8'hF8;
    localparam logic [7:0] SS_8     = 8'h80;
    localparam logic [7:0] SS_9     = 8'h90;
    localparam logic [7:0] SS_BLANK = 8'hFF;
    localparam logic [3:0] DIG_OFF  = 4'b1111;

    // True when digit i of d is a leading zero: it and every digit above it are 0.
    // Digit 0 is never treated as a leading zero so "0" still shows.
    function automatic logic lead_zero(input logic [15:0] d, input logic [1:0] i);
        logic z;
        case (i)
            2'd3:    z = (d[15:12] == 4'd0);
            2'd2:    z = (d[15:8]  == 8'd0);
            2'd1:    z = (d[15:4]  == 12'd0);
            default: z = 1'b0;
        endcase
        return z;
    endfunction

endpackage

// File: rtl/ssd_scan_ctrl_display_select.sv
// BCD to seven-segment decoder shared by all four digit slots.
// Non-decimal codes fall back to the zero pattern.
module display_select
    import ssd_scan_ctrl_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    // Pure lookup; no state.
    always_comb begin
        seg = SS_0;
        case (bcd)
            4'd0:    seg = SS_0;
            4'd1:    seg = SS_1;
            4'd2:    seg = SS_2;
            4'd3:    seg = SS_3;
            4'd4:    seg = SS_4;
            4'd5:    seg = SS_5;
            4'd6:    seg = SS_6;
            4'd7:    seg = SS_7;
            4'd8:    seg = SS_8;
            4'd9:    seg = SS_9;
            default: seg = SS_0;
        endcase
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// One shared decoder is stepped through the digits; new digit values are
// taken only at a frame boundary so a frame never mixes old and new data.
// Each slot change spends one cycle with all digits off to avoid ghosting.
module ssd_scan_ctrl
    import ssd_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits_in,
    input  logic        load,
    input  logic        lz_en,
    input  logic [3:0]  blank_mask,
    output logic        load_ack,
    output logic        frame_done,
    output logic [3:0]  ssd_ctl,
    output logic [7:0]  ssd_out
);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      active;
    logic [15:0]      pend;
    logic             pend_vld;
    logic             tick_d;

    logic        tick;
    logic        boundary;
    logic [1:0]  idx_nxt;
    logic [15:0] active_nxt;
    logic [3:0]  sel_digit;
    logic [7:0]  dec_seg;
    logic [7:0]  pattern;

    assign tick     = (cnt == CNT_W'(SCAN_DIV - 1));
    assign boundary = tick && (idx == 2'd3);
    assign idx_nxt  = idx + 2'd1;

    // Digit set in force after this edge; the first slot of a new frame
    // already shows the freshly committed digits.
    always_comb begin
        active_nxt = active;
        if (boundary && load)
            active_nxt = digits_in;
        else if (boundary && pend_vld)
            active_nxt = pend;
    end

    // Pick the digit for the slot being entered.
    always_comb begin
        sel_digit = active_nxt[3:0];
        case (idx_nxt)
            2'd0:    sel_digit = active_nxt[3:0];
            2'd1:    sel_digit = active_nxt[7:4];
            2'd2:    sel_digit = active_nxt[11:8];
            default: sel_digit = active_nxt[15:12];
        endcase
    end

    display_select u_dec (
        .bcd (sel_digit),
        .seg (dec_seg)
    );

    // Blanking mux: forced blank beats leading-zero suppression beats decode.
    // Mask and lz_en are taken live at the slot change.
    always_comb begin
        pattern = dec_seg;
        if (blank_mask[idx_nxt])
            pattern = SS_BLANK;
        else if (lz_en && lead_zero(active_nxt, idx_nxt))
            pattern = SS_BLANK;
    end

    // Prescaler and scan index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx_nxt;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Load handshake: hold the latest request until the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 16'h0000;
            pend     <= 16'h0000;
            pend_vld <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            load_ack <= boundary && (load || pend_vld);
            active   <= active_nxt;
            if (boundary) begin
                pend_vld <= 1'b0;
            end else if (load) begin
                pend     <= digits_in;
                pend_vld <= 1'b1;
            end
        end
    end

    // Display outputs: all digits off for one cycle after tick, enable the
    // new slot the cycle after that; frame_done follows the boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssd_ctl    <= DIG_OFF;
            ssd_out    <= SS_BLANK;
            tick_d     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tick_d     <= tick;
            frame_done <= boundary;
            if (tick) begin
                ssd_ctl <= DIG_OFF;
                ssd_out <= pattern;
            end else if (tick_d) begin
                ssd_ctl <= ~(4'b0001 << idx);
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl with SCAN_DIV=4: a cycle-count reference model
// checked every cycle, a table of digit/blanking vectors, and a few
// hand-written handshake and reset sequences.
module tb_ssd_scan_ctrl;

    localparam int D = 4;
    localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits_in;
    logic        load;
    logic        lz_en;
    logic [3:0]  blank_mask;
    logic        load_ack;
    logic        frame_done;
    logic [3:0]  ssd_ctl;
    logic [7:0]  ssd_out;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    ssd_scan_ctrl #(.SCAN_DIV(D), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .load       (load),
        .lz_en      (lz_en),
        .blank_mask (blank_mask),
        .load_ack   (load_ack),
        .frame_done (frame_done),
        .ssd_ctl    (ssd_ctl),
        .ssd_out    (ssd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Expected pattern of slot s from the display rules.
    function automatic logic [7:0] pat(input logic [15:0] a, input int s,
                                       input logic [3:0] m, input logic lz);
        int d;
        d = int'((a >> (4 * s)) & 16'hF);
        if (m[s]) return 8'hFF;
        if (lz && s > 0 && (a >> (4 * s)) == 16'h0) return 8'hFF;
        if (d > 9) return SEG[0];
        return SEG[d];
    endfunction

    // Reference model: timing derived from the number of edges since reset.
    int          n;
    logic [15:0] m_act, m_pend;
    bit          m_pv;
    logic [3:0]  e_ctl;
    logic [7:0]  e_out;
    logic        e_ack, e_fd;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; m_act = 16'h0; m_pend = 16'h0; m_pv = 0;
            e_ctl = 4'hF; e_out = 8'hFF; e_ack = 0; e_fd = 0;
        end else begin
            bit tk, bnd;
            tk  = (n % D) == D - 1;
            bnd = tk && ((n / D) % 4 == 3);
            e_ack = bnd && (load || m_pv);
            e_fd  = bnd;
            if (bnd) begin
                if (load) m_act = digits_in;
                else if (m_pv) m_act = m_pend;
                m_pv = 0;
            end else if (load) begin
                m_pend = digits_in;
                m_pv = 1;
            end
            n++;
            if (n < D || n % D == 0) e_ctl = 4'hF;
            else e_ctl = ~(4'b0001 << ((n / D) % 4));
            if (tk) e_out = pat(m_act, (n / D) % 4, blank_mask, lz_en);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ssd_ctl", 32'(ssd_ctl), 32'(e_ctl));
            chk("ssd_out", 32'(ssd_out), 32'(e_out));
            chk("load_ack", 32'(load_ack), 32'(e_ack));
            chk("frame_done", 32'(frame_done), 32'(e_fd));
        end
    end

    typedef struct {
        logic [15:0] dig;
        logic        lz;
        logic [3:0]  mask;
        logic [7:0]  exp [4];
    } vec_t;

    vec_t vt [9];
    int   acks;

    task automatic pulse_load(input logic [15:0] d);
        digits_in = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_frame_pos(input int pos);
        int k;
        for (k = 0; k < 40; k++) begin
            if (n % (4 * D) == pos) break;
            @(negedge clk);
        end
        if (k == 40) chk("frame_pos_timeout", 32'(k), 32'(0));
    endtask

    task automatic count_acks(input int cycles, output int c);
        c = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (load_ack) c++;
        end
    endtask

    initial begin
        vt[0] = '{16'h0000, 1'b0, 4'b0000, '{8'hC0, 8'hC0, 8'hC0, 8'hC0}};
        vt[1] = '{16'h1234, 1'b0, 4'b0000, '{8'h99, 8'hB0, 8'hA4, 8'hF9}};
        vt[2] = '{16'h0070, 1'b1, 4'b0000, '{8'hC0, 8'hF8, 8'hFF, 8'hFF}};
        vt[3] = '{16'h0070, 1'b0, 4'b0000, '{8'hC0, 8'hF8, 8'hC0, 8'hC0}};
        vt[4] = '{16'h8888, 1'b0, 4'b0101, '{8'hFF, 8'h80, 8'hFF, 8'h80}};
        vt[5] = '{16'h9999, 1'b0, 4'b0000, '{8'h90, 8'h90, 8'h90, 8'h90}};
        vt[6] = '{16'h00AF, 1'b0, 4'b0000, '{8'hC0, 8'hC0, 8'hC0, 8'hC0}};
        vt[7] = '{16'h0000, 1'b1, 4'b0000, '{8'hC0, 8'hFF, 8'hFF, 8'hFF}};
        vt[8] = '{16'h0506, 1'b1, 4'b0000, '{8'h82, 8'hC0, 8'h92, 8'hFF}};

        rst_n = 1'b0; digits_in = 16'h0; load = 1'b0; lz_en = 1'b0; blank_mask = 4'h0;
        #12;
        chk("rst_ctl", 32'(ssd_ctl), 32'hF);
        chk("rst_out", 32'(ssd_out), 32'hFF);
        chk("rst_ack", 32'(load_ack), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (40) @(negedge clk);

        // Table vectors: load, wait for the ack, then capture each lit slot.
        for (int v = 0; v < 9; v++) begin
            logic [7:0] got [4];
            bit         seen [4];
            int         k;
            for (int i = 0; i < 4; i++) begin got[i] = 8'h00; seen[i] = 0; end
            lz_en = vt[v].lz;
            blank_mask = vt[v].mask;
            digits_in = vt[v].dig;
            load = 1'b1;
            for (k = 0; k < 40; k++) begin
                @(negedge clk);
                load = 1'b0;
                if (load_ack) break;
            end
            chk($sformatf("vec%0d_ack_timeout", v), 32'(k == 40), 32'(0));
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                for (int i = 0; i < 4; i++)
                    if (ssd_ctl == ~(4'b0001 << i)) begin got[i] = ssd_out; seen[i] = 1; end
            end
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("vec%0d_seen%0d", v, i), 32'(seen[i]), 32'(1));
                chk($sformatf("vec%0d_dig%0d", v, i), 32'(got[i]), 32'(vt[v].exp[i]));
            end
        end
        lz_en = 1'b0; blank_mask = 4'h0;

        // Two loads in one frame: only the last one lands, one ack.
        wait_frame_pos(1);
        pulse_load(16'h1111);
        repeat (2) @(negedge clk);
        pulse_load(16'h5678);
        count_acks(40, acks);
        chk("two_loads_acks", 32'(acks), 32'(1));
        chk("two_loads_active", 32'(m_act), 32'h5678);

        // Load coincident with the boundary: ack in the next cycle, nothing pending.
        wait_frame_pos(4 * D - 1);
        pulse_load(16'h9999);
        chk("bnd_load_ack", 32'(load_ack), 32'(1));
        count_acks(40, acks);
        chk("bnd_load_no_extra_ack", 32'(acks), 32'(0));

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            load = ($urandom_range(0, 7) == 0);
            digits_in = 16'($urandom);
            if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) lz_en = 1'($urandom);
            @(negedge clk);
        end
        load = 1'b0;

        // Async reset mid-slot with a pending load: outputs clear at once.
        blank_mask = 4'h0; lz_en = 1'b0;
        pulse_load(16'h4321);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ctl", 32'(ssd_ctl), 32'hF);
        chk("midrst_out", 32'(ssd_out), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        count_acks(40, acks);
        chk("midrst_pend_dropped", 32'(acks), 32'(0));

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
